// File: rtl/wb_random_slave.sv
`default_nettype none
// ============================================================================
// wb_random_slave : Wishbone slave answering reads with LFSR data and folding
//                   write data into an XOR signature after a fixed latency.
// Revision        : 1.0
// ============================================================================
module wb_random_slave #(
  parameter int           DATA_W      = 128,
  parameter int           ACK_LATENCY = 3,
  parameter logic [127:0] SEED        = 128'h1,
  parameter logic [31:0]  ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0]  ADDR_MASK   = 32'hF000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         i_wb_adr,
  input  logic [DATA_W/8-1:0] i_wb_sel,
  input  logic                i_wb_we,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  output logic [DATA_W-1:0]   o_wr_sig,
  output logic [15:0]         o_rd_cnt,
  output logic [15:0]         o_wr_cnt
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [DATA_W-1:0] c_SEED_EFF = (SEED == '0) ? DATA_W'(1) : DATA_W'(SEED);
  localparam logic [3:0]        c_LAT_LAST = 4'(ACK_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [31:0]         r_adr;
  logic [DATA_W/8-1:0] r_sel;
  logic                r_we;
  logic [DATA_W-1:0]   r_dat;
  logic [DATA_W-1:0]   r_lfsr;
  logic [DATA_W-1:0]   r_sig;
  logic [15:0]         r_rd_cnt;
  logic [15:0]         r_wr_cnt;

  logic                w_req;
  logic                w_hit;
  logic                w_resp;
  logic [DATA_W-1:0]   w_lane_mask;
  logic [DATA_W-1:0]   w_lfsr_next;

  assign w_req       = i_wb_cyc & i_wb_stb;
  assign w_hit       = ((r_adr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign w_resp      = (r_state == S_RESP);
  assign w_lfsr_next = {r_lfsr[126:0], r_lfsr[127] ^ r_lfsr[125] ^ r_lfsr[100] ^ r_lfsr[98]};

  generate
    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      assign w_lane_mask[8*gi +: 8] = {8{r_sel[gi]}};
    end
  endgenerate

  always_comb begin
    w_next   = r_state;
    o_wb_ack = 1'b0;
    o_wb_err = 1'b0;
    o_wb_dat = '0;
    case (r_state)
      S_IDLE: if (w_req) w_next = (ACK_LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!i_wb_cyc)                w_next = S_IDLE;
        else if (r_cnt == c_LAT_LAST) w_next = S_RESP;
      end
      S_RESP: begin
        w_next   = S_IDLE;
        o_wb_ack = w_hit;
        o_wb_err = ~w_hit;
        if (w_hit && !r_we) o_wb_dat = r_lfsr;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_adr    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_dat    <= '0;
      r_lfsr   <= c_SEED_EFF;
      r_sig    <= '0;
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_adr <= i_wb_adr;
        r_sel <= i_wb_sel;
        r_we  <= i_wb_we;
        r_dat <= i_wb_dat;
      end
      // Counter holds the number of cycles already spent since acceptance.
      if (w_next == S_WAIT) r_cnt <= (r_state == S_IDLE) ? 4'd1 : r_cnt + 4'd1;
      else                  r_cnt <= 4'd0;
      if (w_resp && w_hit) begin
        if (r_we) begin
          r_sig <= r_sig ^ (r_dat & w_lane_mask);
          if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
        end else begin
          r_lfsr <= w_lfsr_next;
          if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
        end
      end
    end
  end

  assign o_wr_sig = r_sig;
  assign o_rd_cnt = r_rd_cnt;
  assign o_wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_random_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_random_slave : scoreboard bench for wb_random_slave (latency 3 and 1).
// Revision           : 1.0
// ============================================================================
module tb_wb_random_slave;

  localparam int LAT = 3;

  typedef struct {
    logic         err;
    logic [127:0] dat;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [127:0] lfsr_m;

  // DUT 0: latency 3, seed 1
  logic [31:0]  adr0 = '0;
  logic [15:0]  sel0 = '0;
  logic         we0 = 1'b0, cyc0 = 1'b0, stb0 = 1'b0;
  logic [127:0] wdat0 = '0;
  logic [127:0] dat0, sig0;
  logic         ack0, err0;
  logic [15:0]  rdc0, wrc0;

  // DUT 1: latency 1, seed 0 (falls back to 1)
  logic         cyc1 = 1'b0, stb1 = 1'b0;
  logic [127:0] dat1, sig1;
  logic         ack1, err1;
  logic [15:0]  rdc1, wrc1;

  wb_random_slave #(.DATA_W(128), .ACK_LATENCY(LAT), .SEED(128'h1),
                    .ADDR_BASE(32'h0), .ADDR_MASK(32'hF000_0000)) dut (
    .clk(clk), .reset(reset), .i_wb_adr(adr0), .i_wb_sel(sel0), .i_wb_we(we0),
    .i_wb_dat(wdat0), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .o_wb_dat(dat0),
    .o_wb_ack(ack0), .o_wb_err(err0), .o_wr_sig(sig0), .o_rd_cnt(rdc0), .o_wr_cnt(wrc0));

  wb_random_slave #(.DATA_W(128), .ACK_LATENCY(1), .SEED(128'h0),
                    .ADDR_BASE(32'h0), .ADDR_MASK(32'hF000_0000)) dut1 (
    .clk(clk), .reset(reset), .i_wb_adr(32'h0000_0040), .i_wb_sel(16'hFFFF), .i_wb_we(1'b0),
    .i_wb_dat(128'h0), .i_wb_cyc(cyc1), .i_wb_stb(stb1), .o_wb_dat(dat1),
    .o_wb_ack(ack1), .o_wb_err(err1), .o_wr_sig(sig1), .o_rd_cnt(rdc1), .o_wr_cnt(wrc1));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  // Scoreboard monitors: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ack0 || err0) begin
      if (q0.size() == 0) check("dut0 unexpected ack/err", {ack0, err0}, 2'b00);
      else begin
        e = q0.pop_front();
        check("dut0 ack/err", {ack0, err0}, {~e.err, e.err});
        check("dut0 rdata", dat0, e.dat);
        check("dut0 latency cycle", cyc_cnt, e.cyc);
      end
    end else if (!(ack0 || err0) && dat0 !== '0) check("dut0 idle rdata", dat0, '0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack1 || err1) begin
      if (q1.size() == 0) check("dut1 unexpected ack/err", {ack1, err1}, 2'b00);
      else begin
        e = q1.pop_front();
        check("dut1 ack/err", {ack1, err1}, {~e.err, e.err});
        check("dut1 rdata", dat1, e.dat);
        check("dut1 ack cycle", cyc_cnt, e.cyc);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [15:0] s,
                      input logic [127:0] d, input logic exp_err, input logic [127:0] exp_dat);
    exp_t e;
    @(negedge clk);
    adr0 = a; we0 = w; sel0 = s; wdat0 = d; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk); #1;
    e.err = exp_err; e.dat = exp_dat; e.cyc = cyc_cnt + LAT - 1;
    q0.push_back(e);
    repeat (LAT) @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;
  endtask

  // Hit read: expected data is the model LFSR, which then steps.
  task automatic rd_hit(input logic [31:0] a);
    xfer(a, 1'b0, 16'hFFFF, '0, 1'b0, lfsr_m);
    lfsr_m = step(lfsr_m);
  endtask

  // Request accepted but not expected to complete (abort or reset).
  task automatic start_only(input logic [31:0] a);
    @(negedge clk);
    adr0 = a; we0 = 1'b0; sel0 = 16'hFFFF; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   base;
    lfsr_m = 128'h1;
    repeat (3) @(negedge clk);
    check("reset ack", ack0, 0);
    check("reset err", err0, 0);
    check("reset rdata", dat0, 0);
    check("reset sig", sig0, 0);
    check("reset rd_cnt", rdc0, 0);
    check("reset wr_cnt", wrc0, 0);
    reset = 1'b1;

    rd_hit(32'h0000_0010);
    rd_hit(32'h0000_0010);
    @(negedge clk); check("rd_cnt after 2 reads", rdc0, 16'd2);

    xfer(32'h1000_0000, 1'b0, 16'hFFFF, '0, 1'b1, '0);
    @(negedge clk); check("rd_cnt after miss", rdc0, 16'd2);
    rd_hit(32'h0000_0010);
    check("lfsr model after miss", lfsr_m, 128'h8);

    start_only(32'h0000_0010);
    cyc0 = 1'b0; stb0 = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_cnt after abort", rdc0, 16'd3);
    rd_hit(32'h0000_0010);

    xfer(32'h0000_0020, 1'b1, 16'h0003, {128{1'b1}}, 1'b0, '0);
    @(negedge clk); check("sig after write 1", sig0, 128'hFFFF);
    xfer(32'h0000_0020, 1'b1, 16'h0003, {128{1'b1}}, 1'b0, '0);
    @(negedge clk); check("sig after write 2", sig0, 128'h0);
    check("wr_cnt after 2 writes", wrc0, 16'd2);
    xfer(32'h0000_0030, 1'b1, 16'h8001, {128{1'b1}}, 1'b0, '0);
    @(negedge clk); check("sig lanes 15,0", sig0, {8'hFF, 112'h0, 8'hFF});
    xfer(32'h2000_0000, 1'b1, 16'hFFFF, {128{1'b1}}, 1'b1, '0);
    @(negedge clk); check("sig after write miss", sig0, {8'hFF, 112'h0, 8'hFF});
    check("wr_cnt after write miss", wrc0, 16'd3);

    dut.r_rd_cnt = 16'hFFFE;
    rd_hit(32'h0000_0010);
    @(negedge clk); check("rd_cnt reaches FFFF", rdc0, 16'hFFFF);
    rd_hit(32'h0000_0010);
    rd_hit(32'h0000_0010);
    @(negedge clk); check("rd_cnt saturated", rdc0, 16'hFFFF);

    start_only(32'h0000_0010);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; cyc0 = 1'b0; stb0 = 1'b0;
    repeat (4) @(negedge clk);
    check("post-reset ack", ack0, 0);
    check("post-reset err", err0, 0);
    check("post-reset sig", sig0, 0);
    check("post-reset rd_cnt", rdc0, 0);
    check("post-reset wr_cnt", wrc0, 0);
    lfsr_m = 128'h1;
    rd_hit(32'h0000_0010);

    // Latency-1 slave with the strobe held: one ack every two cycles.
    lfsr_m = 128'h1;
    @(negedge clk);
    cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    base = cyc_cnt;
    for (int k = 0; k < 5; k++) begin
      e.err = 1'b0; e.dat = lfsr_m; e.cyc = base + 2*k;
      q1.push_back(e);
      lfsr_m = step(lfsr_m);
    end
    repeat (9) @(negedge clk);
    cyc1 = 1'b0; stb1 = 1'b0;
    repeat (3) @(negedge clk);
    check("dut1 rd_cnt", rdc1, 16'd5);
    check("dut1 err idle", err1, 0);

    repeat (3) @(negedge clk);
    check("dut0 pending expectations", q0.size(), 0);
    check("dut1 pending expectations", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
